// File: rtl/ifft32_twiddle_sequencer.sv
// ---------------------------------------------------------------------------
// ifft32_twiddle_sequencer
//
// Address and twiddle-index sequencer for a 32-point radix-2 in-place
// decimation-in-frequency IFFT. It walks 5 stages of 16 butterflies. For each
// butterfly it presents the two data-memory addresses and the twiddle ROM
// index on a ready/valid interface. A programmable drain gap between stages
// gives the butterfly pipeline time to retire its writes before the next
// stage reads them.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start_i      one-cycle request to run a transform (honoured in IDLE only)
//   bf_ready_i   datapath accepts the current butterfly
//   bf_valid_o   addr_a_o/addr_b_o/index_r_o/index_i_o/stage_o are valid
//   addr_a_o     upper-leg data address
//   addr_b_o     lower-leg data address (addr_a_o + span)
//   index_r_o    twiddle ROM real-part index
//   index_i_o    twiddle ROM imaginary-part index (same as index_r_o)
//   stage_o      current stage 0..4
//   busy_o       high in every state except IDLE
//   done_o       one-cycle completion pulse
// ---------------------------------------------------------------------------
module ifft32_twiddle_sequencer #(
    parameter int BF_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       bf_ready_i,
    output logic       bf_valid_o,
    output logic [4:0] addr_a_o,
    output logic [4:0] addr_b_o,
    output logic [4:0] index_r_o,
    output logic [4:0] index_i_o,
    output logic [2:0] stage_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] LAT = BF_LATENCY[3:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] stage_q, stage_d;
    logic [3:0] b_q, b_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [4:0] addr_a_q, addr_a_d;
    logic [4:0] addr_b_q, addr_b_d;
    logic [4:0] index_q, index_d;

    // address arithmetic intermediates
    logic [4:0] span;
    logic [4:0] mask;
    logic [4:0] b_ext;
    logic [4:0] offset;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            stage_q  <= 3'd0;
            b_q      <= 4'd0;
            cnt_q    <= 4'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= 5'd0;
            addr_b_q <= 5'd0;
            index_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            index_q  <= index_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start_i) begin
                    state_d = S_ISSUE;
                    stage_d = 3'd0;
                    b_d     = 4'd0;
                    busy_d  = 1'b1;
                end
            end

            S_ISSUE: begin
                if (!valid_q) begin
                    // First cycle after start: outputs for b=0 are being
                    // loaded, raise valid on the next edge.
                    valid_d = 1'b1;
                end else if (bf_ready_i) begin
                    if (b_q != 4'd15) begin
                        b_d = b_q + 4'd1;
                    end else if (LAT != 4'd0) begin
                        state_d = S_DRAIN;
                        valid_d = 1'b0;
                        cnt_d   = LAT;
                    end else if (stage_q == 3'd4) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Zero-latency pipeline: next stage starts back-to-back.
                        stage_d = stage_q + 3'd1;
                        b_d     = 4'd0;
                    end
                end
            end

            S_DRAIN: begin
                if (cnt_q == 4'd1) begin
                    cnt_d = 4'd0;
                    if (stage_q == 3'd4) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Outputs for the next stage's b=0 are loaded on the
                        // same edge so no extra bubble appears.
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                        stage_d = stage_q + 3'd1;
                        b_d     = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / twiddle arithmetic from the next stage and butterfly.
    // span = 16 >> stage; offset = b & (span-1);
    // group*2*span = (b & ~(span-1)) << 1; k = offset << stage.
    // Outputs hold while returning to / sitting in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        span     = 5'd16 >> stage_d;
        mask     = span - 5'd1;
        b_ext    = {1'b0, b_d};
        offset   = b_ext & mask;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        index_d  = index_q;
        if (state_d != S_IDLE) begin
            addr_a_d = ((b_ext & ~mask) << 1) | offset;
            addr_b_d = addr_a_d + span;
            index_d  = offset << stage_d;
        end
    end

    assign bf_valid_o = valid_q;
    assign addr_a_o   = addr_a_q;
    assign addr_b_o   = addr_b_q;
    assign index_r_o  = index_q;
    assign index_i_o  = index_q;
    assign stage_o    = stage_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_ifft32_twiddle_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for ifft32_twiddle_sequencer. Two instances: one with
// BF_LATENCY=4 and one with BF_LATENCY=0. Each beat is checked against a
// reference computed with plain division/modulo arithmetic, and stage gaps,
// completion latency, address coverage and reset behaviour are checked.
// ---------------------------------------------------------------------------
module tb_ifft32_twiddle_sequencer;

    logic clk;
    logic rst;
    logic start4, start0;
    logic ready;

    logic       v4, busy4, done4;
    logic [4:0] a4, b4, ir4, ii4;
    logic [2:0] st4;
    logic       v0, busy0, done0;
    logic [4:0] a0, b0, ir0, ii0;
    logic [2:0] st0;

    int checks   = 0;
    int failures = 0;
    int sel_g    = 0;

    // observed signals of the instance currently under test
    logic       valid_m, busy_m, done_m;
    logic [4:0] addr_a_m, addr_b_m, idx_r_m, idx_i_m;
    logic [2:0] stage_m;

    assign valid_m  = (sel_g == 1) ? v0    : v4;
    assign busy_m   = (sel_g == 1) ? busy0 : busy4;
    assign done_m   = (sel_g == 1) ? done0 : done4;
    assign addr_a_m = (sel_g == 1) ? a0    : a4;
    assign addr_b_m = (sel_g == 1) ? b0    : b4;
    assign idx_r_m  = (sel_g == 1) ? ir0   : ir4;
    assign idx_i_m  = (sel_g == 1) ? ii0   : ii4;
    assign stage_m  = (sel_g == 1) ? st0   : st4;

    ifft32_twiddle_sequencer #(.BF_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .bf_ready_i(ready),
        .bf_valid_o(v4), .addr_a_o(a4), .addr_b_o(b4),
        .index_r_o(ir4), .index_i_o(ii4), .stage_o(st4),
        .busy_o(busy4), .done_o(done4)
    );

    ifft32_twiddle_sequencer #(.BF_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .bf_ready_i(ready),
        .bf_valid_o(v0), .addr_a_o(a0), .addr_b_o(b0),
        .index_r_o(ir0), .index_i_o(ii0), .stage_o(st0),
        .busy_o(busy0), .done_o(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) begin
            start0 = v;
            start4 = 1'b0;
        end else begin
            start4 = v;
            start0 = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, valid_m, 0);
        chk({tag, "_busy"},  busy_m, 0);
        chk({tag, "_done"},  done_m, 0);
        chk({tag, "_addr_a"}, addr_a_m, 0);
        chk({tag, "_addr_b"}, addr_b_m, 0);
        chk({tag, "_idx_r"}, idx_r_m, 0);
        chk({tag, "_idx_i"}, idx_i_m, 0);
        chk({tag, "_stage"}, stage_m, 0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: 3-cycle stall at stage 2, b=7
    // poke: pulse start while busy and again during the done cycle
    task automatic run(input int sel, input int lat, input int mode, input bit poke);
        int beat, cyc, stalls, done_cyc, done_cnt, gap, stall_used, full;
        int s, bb, span, ea, ek;
        bit prev_valid, rdy;
        int cov[5][32];
        int spot_beat[6];
        int spot_a[6];
        int spot_b[6];
        int spot_k[6];
        spot_beat = '{0, 3, 26, 37, 39, 79};
        spot_a    = '{0, 3, 18,  9, 11, 30};
        spot_b    = '{16, 19, 26, 13, 15, 31};
        spot_k    = '{0, 3,  4,  4, 12,  0};
        beat = 0; stalls = 0; done_cyc = -1; done_cnt = 0; gap = 0; stall_used = 0;
        prev_valid = 0;
        foreach (cov[i, j]) cov[i][j] = 0;
        sel_g = sel;
        ready = 1'b1;
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
        cyc = 0;
        chk("valid_prime", valid_m, 0);
        while (cyc < 700 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
            if (done_cyc < 0 || cyc <= done_cyc) chk("busy_running", busy_m, 1);
            else chk("busy_after_done", busy_m, 0);

            if (valid_m && beat < 80) begin
                s    = beat / 16;
                bb   = beat % 16;
                span = 16 >> s;
                ea   = (bb / span) * 2 * span + (bb % span);
                ek   = (bb % span) * (1 << s);
                if (!prev_valid && beat > 0) chk("stage_gap", gap, (bb == 0) ? lat : 0);
                chk("addr_a", addr_a_m, ea);
                chk("addr_b", addr_b_m, ea + span);
                chk("index_r", idx_r_m, ek);
                chk("index_i_eq_r", idx_i_m, idx_r_m);
                chk("stage", stage_m, s);
                for (int p = 0; p < 6; p++) begin
                    if (beat == spot_beat[p]) begin
                        chk("spot_addr_a", addr_a_m, spot_a[p]);
                        chk("spot_addr_b", addr_b_m, spot_b[p]);
                        chk("spot_index", idx_r_m, spot_k[p]);
                    end
                end
            end
            if (valid_m) gap = 0;
            else if (beat > 0) gap++;

            if (done_m) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_valid = valid_m;

            case (mode)
                1:       rdy = ($urandom_range(0, 3) != 0);
                2:       rdy = !(valid_m && beat == 39 && stall_used < 3);
                default: rdy = 1'b1;
            endcase
            if (mode == 2 && !rdy) stall_used++;
            ready = rdy;
            if (valid_m) begin
                if (rdy) begin
                    if (beat < 80) begin
                        cov[beat / 16][addr_a_m]++;
                        cov[beat / 16][addr_b_m]++;
                    end
                    beat++;
                end else begin
                    stalls++;
                end
            end
            if (poke && (cyc == 30 || done_m)) set_start(sel, 1'b1);
            else set_start(sel, 1'b0);

            @(negedge clk);
            cyc++;
        end
        set_start(sel, 1'b0);
        ready = 1'b1;
        chk("transfers", beat, 80);
        chk("done_pulses", done_cnt, 1);
        chk("done_cycle", done_cyc, 81 + stalls + 5 * lat);
        if (mode == 2) chk("stall_cycles", stalls, 3);
        for (int st = 0; st < 5; st++) begin
            full = 0;
            for (int ad = 0; ad < 32; ad++) if (cov[st][ad] == 1) full++;
            chk("stage_coverage", full, 32);
        end
        chk("idle_valid", valid_m, 0);
        $display("run sel=%0d lat=%0d mode=%0d beats=%0d stalls=%0d done_cycle=%0d",
                 sel, lat, mode, beat, stalls, done_cyc);
    endtask

    initial begin : main
        int n, xfers, done_seen, busy_seen;
        rst = 1'b1; start4 = 1'b0; start0 = 1'b0; ready = 1'b1;
        #1;
        sel_g = 0; #0 chk_all_zero("reset4");
        sel_g = 1; #0 chk_all_zero("reset0");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sel_g = 0; #0 chk_all_zero("idle_after_reset");

        run(0, 4, 0, 1'b0);   // nominal, BF_LATENCY=4
        run(0, 4, 2, 1'b0);   // directed back-pressure
        run(0, 4, 1, 1'b1);   // random back-pressure plus ignored starts
        run(1, 0, 0, 1'b0);   // BF_LATENCY=0, contiguous
        run(1, 0, 1, 1'b0);   // BF_LATENCY=0, random back-pressure

        // asynchronous reset during the drain after stage 1
        sel_g = 0; ready = 1'b1;
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        n = 0; xfers = 0;
        while (n < 300 && !(xfers == 32 && !valid_m)) begin
            if (valid_m) xfers++;
            @(negedge clk);
            n++;
        end
        chk("abort_reached_drain", xfers, 32);
        chk("abort_in_drain_busy", busy_m, 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge clk); rst = 1'b0;
        done_seen = 0; busy_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_m) done_seen++;
            if (busy_m || valid_m) busy_seen++;
        end
        chk("no_done_after_abort", done_seen, 0);
        chk("stays_idle_after_abort", busy_seen, 0);
        $display("abort run: transfers=%0d before reset", xfers);

        run(0, 4, 0, 1'b0);   // clean restart after reset

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifft32_twiddle_sequencer.md
# ifft32_twiddle_sequencer

Address and twiddle-index sequencer for the 32-point radix-2 in-place decimation-in-frequency IFFT core. It walks 5 stages of 16 butterflies each. For every butterfly it issues the two data-memory addresses and the 5-bit index that drives the twiddle ROM's real and imaginary ports. A ready/valid handshake lets the butterfly datapath back-pressure it. A programmable drain gap between stages covers the datapath's read-after-write hazard.

## Interface
Parameters:
- BF_LATENCY, default 4: cycles the butterfly pipeline needs between the last issue of one stage and the first issue of the next (0 to 15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to run a full transform; honoured only in IDLE.
- bf_ready  input  1  datapath accepts the current butterfly.
- bf_valid  output  1  addr_a, addr_b, index_r, index_i and stage are valid.
- addr_a  output  5  upper-leg data address.
- addr_b  output  5  lower-leg data address, always addr_a + span.
- index_r  output  5  twiddle ROM real-part index.
- index_i  output  5  twiddle ROM imaginary-part index; always equal to index_r.
- stage  output  3  current stage, 0 to 4.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the transform completes.

## Operation
- State machine: IDLE, ISSUE, DRAIN, DONE. State is encoded in registers, and all outputs are registered.
- IDLE to ISSUE: on start. This loads stage=0 and butterfly counter b=0.
- ISSUE: bf_valid=1. On bf_valid & bf_ready, b increments.
  - When b=15 is accepted, the next state is DRAIN if BF_LATENCY>0.
  - If BF_LATENCY=0, the next state is ISSUE for the next stage, or DONE when stage=4.
- DRAIN: bf_valid=0. A down-counter is loaded with BF_LATENCY.
  - When the counter reaches 1, the next state is DONE if stage=4.
  - Otherwise the next state is ISSUE with stage+1 and b=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- Address arithmetic, with span = 16 >> stage:
  - group = b / span; offset = b mod span.
  - addr_a = group*2*span + offset.
  - addr_b = addr_a + span.
  - twiddle k = offset << stage. k lies in 0..15, so index bit 4 is always 0.
  - Implement the arithmetic with shifts and masks only; no dividers.
- index_r = index_i = k. The ROM maps the same k to cos and sin.
- Stage 0 uses every twiddle 0..15. Stage 4 uses k=0 only.

## Timing
- Reset values:
  - state=IDLE.
  - bf_valid=0, busy=0, done=0.
  - addr_a=0, addr_b=0, index_r=0, index_i=0, stage=0.
  - b=0, drain counter=0.
- Start handshake:
  - start is sampled at edge N. bf_valid is high after edge N+1, carrying stage 0, b=0.
  - start while busy is ignored; no restart or queueing.
- Issue handshake:
  - A transfer occurs on any edge where bf_valid & bf_ready are both high.
  - While bf_valid=1 and bf_ready=0, all issue outputs hold stable.
  - bf_valid never drops without a transfer.
- Throughput: with bf_ready held high, one butterfly per cycle, with 16 consecutive valid cycles per stage.
- Stage gap: exactly BF_LATENCY bf_valid-low cycles between stages. There is no gap after stage 4 beyond the same drain.
- Completion latency: with bf_ready held high, done is high 80 + 5*BF_LATENCY + 1 cycles after start is sampled.
- busy is high from the cycle after start through the done cycle inclusive.
- Wrap-around: b wraps from 15 to 0 only on stage advance. Stage never exceeds 4.
- Mid-operation reset: rst asserted asynchronously in any state forces the reset values immediately. No done pulse is issued. A new start is required after rst deasserts.
- start coinciding with the done cycle is ignored; start is honoured only from IDLE.

## Test plan
- Reset and start, BF_LATENCY=4, bf_ready=1: reset values hold after rst. The first valid beat has addr_a=0, addr_b=16, index=0, stage=0. done is high 101 cycles after start.
- Address spot checks:
  - stage 0, b=3 gives addr_a=3, addr_b=19, index=3.
  - stage 1, b=10 gives addr_a=18, addr_b=26, index=4.
  - stage 2, b=5 gives addr_a=9, addr_b=13, index=4.
  - stage 4, b=15 gives addr_a=30, addr_b=31, index=0.
- Back-pressure: drop bf_ready for 3 cycles at stage 2, b=7. Outputs hold addr_a=11, addr_b=15, index=12. Exactly 80 transfers occur in total. done is delayed by 3 cycles.
- Coverage check: each stage's 32 addresses (addr_a ∪ addr_b) are covered exactly once. index_r equals index_i on every beat.
- BF_LATENCY=0: there are 80 contiguous valid beats. done is high at cycle 81 after start.
- Async reset during DRAIN after stage 1: all outputs go to 0 immediately and no done pulse appears. start pulsed while busy in a separate run has no effect on the sequence.
